// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory slot arbiter.
// Slot phases are derived from the CPU period length (DIV) and the two
// fixed service slots. The CPU RAM access is issued two phases before the
// CPU strobe so that the read data can be registered in between.
package mem_arb_pkg;

    localparam int DIV      = 16;
    localparam int CPU_SLOT = 15;
    localparam int VID_SLOT = 7;
    localparam int AW       = 16;
    localparam int PHASE_W  = $clog2(DIV);

    localparam logic [PHASE_W-1:0] PH_CPU_ACC = PHASE_W'(CPU_SLOT - 2);
    localparam logic [PHASE_W-1:0] PH_CPU_CAP = PHASE_W'(CPU_SLOT - 1);
    localparam logic [PHASE_W-1:0] PH_CPU_EN  = PHASE_W'(CPU_SLOT);
    localparam logic [PHASE_W-1:0] PH_VID_REQ = PHASE_W'(VID_SLOT);
    localparam logic [PHASE_W-1:0] PH_VID_ACK = PHASE_W'(VID_SLOT + 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STRETCH = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_slot_counter.sv
// Phase counter for the memory slot arbiter.
// Counts 0..DIV-1 once per CLK and wraps; mhz1 toggles on every wrap so it
// marks alternate CPU periods (the 1MHz bus phase).
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   phase       current phase within the CPU period
//   mhz1        alternating-period flag
//   wrap        high in the last phase of a period
module mem_slot_counter #(
    parameter int DIV     = 16,
    parameter int PHASE_W = $clog2(DIV)
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic [PHASE_W-1:0] phase,
    output logic               mhz1,
    output logic               wrap
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               mhz1_q, mhz1_d;

    always_comb begin
        wrap    = (phase_q == PHASE_W'(DIV - 1));
        phase_d = wrap ? '0 : phase_q + 1'b1;
        mhz1_d  = mhz1_q ^ wrap;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q <= '0;
            mhz1_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mhz1_q  <= mhz1_d;
        end
    end

    assign phase = phase_q;
    assign mhz1  = mhz1_q;

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slot scheduler sharing one synchronous-read RAM between the 6502
// core and a video fetch port, and generator of the CPU clock enable.
// Optional feature: SLOW_BUS_STRETCH_EN stretches CPU cycles that target
// the 1MHz peripheral region until a period with mhz1=1.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal DIV-CLK CPU cycles, CPU RAM slot active
// ST_STRETCH | slow peripheral cycle in progress, CPU strobe held off
//
// Ports:
//   CLK, RESET                      clock, asynchronous active-high reset
//   CPU_CLK_en                      CPU cycle-end strobe
//   CPU_Address/RnW/Data_out        CPU bus inputs
//   CPU_Data_in                     registered read data to CPU
//   SLOW_sel, PERIPH_stb/rdata      1MHz peripheral access
//   VID_req/addr, VID_ack/data      video fetch port
//   RAM_addr/we/wdata, RAM_rdata    system RAM interface (1-CLK read latency)
module mem_slot_arbiter
    import mem_arb_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    output logic          CPU_CLK_en,
    input  logic [15:0]   CPU_Address,
    input  logic          CPU_RnW,
    input  logic [7:0]    CPU_Data_out,
    output logic [7:0]    CPU_Data_in,
    input  logic          SLOW_sel,
    output logic          PERIPH_stb,
    input  logic [7:0]    PERIPH_rdata,
    input  logic          VID_req,
    input  logic [AW-1:0] VID_addr,
    output logic          VID_ack,
    output logic [7:0]    VID_data,
    output logic [AW-1:0] RAM_addr,
    output logic          RAM_we,
    output logic [7:0]    RAM_wdata,
    input  logic [7:0]    RAM_rdata
);

    logic [PHASE_W-1:0] phase;
    logic               mhz1;
    logic               wrap;

    logic [AW-1:0] ram_addr_q;
    logic [7:0]    ram_wdata_q;
    logic [7:0]    cpu_data_q, cpu_data_d;
    logic [7:0]    vid_data_q;
    logic          vid_pend_q, vid_pend_d;

    logic in_run;
    logic end_period;
    logic periph_period;
    logic cpu_ram;
    logic vid_issue;

    mem_slot_counter #(.DIV(DIV), .PHASE_W(PHASE_W)) u_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .phase (phase),
        .mhz1  (mhz1),
        .wrap  (wrap)
    );

`ifdef SLOW_BUS_STRETCH_EN
    arb_state_t state_q, state_d;
    logic       seen_wrap_q, seen_wrap_d;
    logic       final_period;

    // The release period must come strictly after the one that started the
    // stretch, hence seen_wrap rather than mhz1 alone.
    always_comb begin
        final_period  = (state_q == ST_STRETCH) && seen_wrap_q && mhz1;
        in_run        = (state_q == ST_RUN);
        end_period    = in_run || final_period;
        periph_period = final_period;
    end

    always_comb begin
        state_d     = state_q;
        seen_wrap_d = seen_wrap_q | wrap;
        case (state_q)
            ST_RUN: begin
                if (phase == PH_CPU_ACC && SLOW_sel) begin
                    state_d     = ST_STRETCH;
                    seen_wrap_d = 1'b0;
                end
            end
            ST_STRETCH: begin
                if (final_period && phase == PH_CPU_EN)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            seen_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_wrap_q <= seen_wrap_d;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^{mhz1, wrap};

    always_comb begin
        in_run        = 1'b1;
        end_period    = 1'b1;
        periph_period = SLOW_sel;
    end
`endif

    // CPU and video slots are distinct phases, so the address mux never
    // sees both at once; between accesses the RAM address simply holds.
    always_comb begin
        cpu_ram    = in_run && (phase == PH_CPU_ACC) && !SLOW_sel;
        vid_issue  = (phase == PH_VID_REQ) && VID_req;
        vid_pend_d = vid_issue;

        RAM_we    = cpu_ram && !CPU_RnW;
        RAM_wdata = RAM_we ? CPU_Data_out : ram_wdata_q;
        if (cpu_ram)
            RAM_addr = CPU_Address;
        else if (vid_issue)
            RAM_addr = VID_addr;
        else
            RAM_addr = ram_addr_q;

        CPU_CLK_en = end_period && (phase == PH_CPU_EN);
        PERIPH_stb = periph_period && (phase == PH_CPU_CAP);

        cpu_data_d = cpu_data_q;
        if (PERIPH_stb && CPU_RnW)
            cpu_data_d = PERIPH_rdata;
        else if (in_run && (phase == PH_CPU_CAP) && !SLOW_sel && CPU_RnW)
            cpu_data_d = RAM_rdata;

        VID_ack  = vid_pend_q;
        VID_data = vid_pend_q ? RAM_rdata : vid_data_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_data_q  <= '0;
            vid_data_q  <= '0;
            vid_pend_q  <= 1'b0;
        end else begin
            ram_addr_q  <= RAM_addr;
            ram_wdata_q <= RAM_wdata;
            cpu_data_q  <= cpu_data_d;
            vid_data_q  <= VID_data;
            vid_pend_q  <= vid_pend_d;
        end
    end

    assign CPU_Data_in = cpu_data_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
module tb_mem_slot_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_CLK_en;
    logic [15:0] CPU_Address = '0;
    logic        CPU_RnW = 1'b1;
    logic [7:0]  CPU_Data_out = '0;
    logic [7:0]  CPU_Data_in;
    logic        SLOW_sel = 1'b0;
    logic        PERIPH_stb;
    logic [7:0]  PERIPH_rdata = '0;
    logic        VID_req = 1'b0;
    logic [15:0] VID_addr = '0;
    logic        VID_ack;
    logic [7:0]  VID_data;
    logic [15:0] RAM_addr;
    logic        RAM_we;
    logic [7:0]  RAM_wdata;
    logic [7:0]  RAM_rdata = '0;

    mem_slot_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CPU_CLK_en   (CPU_CLK_en),
        .CPU_Address  (CPU_Address),
        .CPU_RnW      (CPU_RnW),
        .CPU_Data_out (CPU_Data_out),
        .CPU_Data_in  (CPU_Data_in),
        .SLOW_sel     (SLOW_sel),
        .PERIPH_stb   (PERIPH_stb),
        .PERIPH_rdata (PERIPH_rdata),
        .VID_req      (VID_req),
        .VID_addr     (VID_addr),
        .VID_ack      (VID_ack),
        .VID_data     (VID_data),
        .RAM_addr     (RAM_addr),
        .RAM_we       (RAM_we),
        .RAM_wdata    (RAM_wdata),
        .RAM_rdata    (RAM_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         len;
        logic [7:0] data;
        bit         slow;
    } cpu_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    cpu_exp_t   cpu_q[$];
    wr_exp_t    wr_q[$];
    logic [7:0] vid_q[$];

    int errors = 0;
    int checks = 0;
    int pos_cnt = 0;
    int rel_pos = 0;
    int last_strobe = 0;
    bit stb_seen = 0;

    // RAM model: untouched locations read as a fixed address pattern.
    logic [7:0] mem [0:65535];
    bit         written [0:65535];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge CLK) begin
        pos_cnt <= pos_cnt + 1;
        if (RAM_we) begin
            mem[RAM_addr]     <= RAM_wdata;
            written[RAM_addr] <= 1'b1;
        end
        RAM_rdata <= written[RAM_addr] ? mem[RAM_addr] : pat(RAM_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output strobe.
    always @(negedge CLK) begin
        if (RESET) begin
            rel_pos     = pos_cnt;
            last_strobe = pos_cnt;
            stb_seen    = 0;
        end else begin
            if (RAM_we) begin
                chk("we_phase", 64'((pos_cnt - rel_pos) % 16), 64'd13);
                if (wr_q.size() == 0) chk("we_unexpected", 64'd1, 64'd0);
                else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("we_addr", 64'(RAM_addr), 64'(w.addr));
                    chk("we_data", 64'(RAM_wdata), 64'(w.data));
                end
            end
            if (VID_ack) begin
                chk("vid_phase", 64'((pos_cnt - rel_pos) % 16), 64'd8);
                if (vid_q.size() == 0) chk("vid_unexpected", 64'd1, 64'd0);
                else chk("vid_data", 64'(VID_data), 64'(vid_q.pop_front()));
            end
            if (PERIPH_stb) begin
                chk("stb_phase", 64'((pos_cnt - rel_pos) % 16), 64'd14);
                stb_seen = 1;
            end
            if (CPU_CLK_en) begin
                if (cpu_q.size() == 0) chk("clken_unexpected", 64'd1, 64'd0);
                else begin
                    cpu_exp_t c;
                    c = cpu_q.pop_front();
                    chk("cycle_len", 64'(pos_cnt - last_strobe), 64'(c.len));
                    chk("cpu_data", 64'(CPU_Data_in), 64'(c.data));
                    chk("periph_stb", 64'(stb_seen), 64'(c.slow));
                end
                last_strobe = pos_cnt;
                stb_seen    = 0;
            end
        end
    end

    task automatic wait_strobe();
        bit got;
        got = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (CPU_CLK_en) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("strobe_timeout", 64'd1, 64'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                             input logic slow, input logic [7:0] prd, input int len,
                             input logic [7:0] exp_d);
        CPU_Address  = a;
        CPU_RnW      = rnw;
        CPU_Data_out = wd;
        SLOW_sel     = slow;
        PERIPH_rdata = prd;
        cpu_q.push_back('{len, exp_d, slow});
        if (!slow && !rnw) wr_q.push_back('{a, wd});
        wait_strobe();
    endtask

    task automatic check_zero(input string name);
        chk(name, {CPU_CLK_en, PERIPH_stb, VID_ack, RAM_we, RAM_addr, RAM_wdata,
                   CPU_Data_in, VID_data}, 64'd0);
    endtask

    // Slow cycle length in CLKs given the index of the period it starts in.
    function automatic int slow_len(input int p);
`ifdef SLOW_BUS_STRETCH_EN
        return (p % 2 == 1) ? 48 : 32;
`else
        return 16;
`endif
    endfunction

    int p;
    int wait_n;

    initial begin
        p = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset_outputs");
        #1 RESET = 1'b0;

        cpu_cycle(16'h2000, 1'b0, 8'hA5, 1'b0, 8'h00, 15, 8'h00);  p += 1;
        cpu_cycle(16'h2000, 1'b1, 8'h00, 1'b0, 8'h00, 16, 8'hA5);  p += 1;

        VID_addr = 16'h3000;
        VID_req  = 1'b1;
        vid_q.push_back(pat(16'h3000));
        vid_q.push_back(pat(16'h3000));
        cpu_cycle(16'h3001, 1'b1, 8'h00, 1'b0, 8'h00, 16, pat(16'h3001));  p += 1;
        cpu_cycle(16'h3001, 1'b1, 8'h00, 1'b0, 8'h00, 16, pat(16'h3001));  p += 1;
        VID_req = 1'b0;

        cpu_cycle(16'hFE40, 1'b1, 8'h00, 1'b1, 8'h5C, slow_len(p), 8'h5C);
        p += slow_len(p) / 16;
        cpu_cycle(16'h2000, 1'b1, 8'h00, 1'b0, 8'h00, 16, 8'hA5);  p += 1;
        cpu_cycle(16'hFE40, 1'b1, 8'h00, 1'b1, 8'h3C, slow_len(p), 8'h3C);
        p += slow_len(p) / 16;
        cpu_cycle(16'hFE41, 1'b0, 8'h77, 1'b1, 8'h00, slow_len(p), 8'h3C);
        p += slow_len(p) / 16;
        PERIPH_rdata = 8'h00;

        // Reset in the middle of a slow cycle with a video request pending.
        CPU_Address = 16'hFE40;
        CPU_RnW     = 1'b1;
        SLOW_sel    = 1'b1;
        VID_addr    = 16'h1234;
        VID_req     = 1'b1;
`ifdef SLOW_BUS_STRETCH_EN
        vid_q.push_back(pat(16'h1234));
        wait_n = 23;
`else
        wait_n = 7;
`endif
        repeat (wait_n) @(posedge CLK);
        #2 RESET = 1'b1;
        VID_req  = 1'b0;
        SLOW_sel = 1'b0;
        @(negedge CLK);
        check_zero("midop_reset_outputs");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RESET = 1'b0;

        cpu_cycle(16'h3001, 1'b1, 8'h00, 1'b0, 8'h00, 15, pat(16'h3001));
        cpu_cycle(16'h2000, 1'b1, 8'h00, 1'b0, 8'h00, 16, 8'hA5);

        repeat (4) @(posedge CLK);
        chk("cpu_q_empty", 64'(cpu_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("vid_q_empty", 64'(vid_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
